wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: MDU result FIFO entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive pipeline grants tolerated while the FIFO is non-empty.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 wb_rd_addr_i  in  5  pipeline WB destination; 0 = no request.
REQ-006 wb_rd_wdata_i  in  32  pipeline WB data.
REQ-007 mdu_valid_i  in  1  multi-cycle unit result valid.
REQ-008 mdu_rd_addr_i  in  5  MDU result destination.
REQ-009 mdu_rd_wdata_i  in  32  MDU result data.
REQ-010 mdu_ready_o  out  1  FIFO can accept a result this cycle.
REQ-011 rf_rd_addr_o  out  5  regfile write address; 0 = no write.
REQ-012 rf_rd_wdata_o  out  32  regfile write data.
REQ-013 wb_stall_o  out  1  pipeline WB denied this cycle; hold WB inputs.

Function
REQ-014 The block SHALL share the single regfile write port between the pipeline WB request and the head of an internal DEPTH-entry MDU result FIFO.
REQ-015 A pipeline request SHALL exist only when wb_rd_addr_i != 0; a FIFO request SHALL exist only when count > 0.
REQ-016 mdu_ready_o SHALL equal (count < DEPTH), registered-state only; no push-when-full even with a same-cycle pop.
REQ-017 Push SHALL occur on mdu_valid_i && mdu_ready_o; an MDU result with rd = 0 SHALL be accepted and discarded (not enqueued).
REQ-018 FIFO SHALL be in-order; minimum accept-to-regfile latency is 1 cycle; no combinational bypass from mdu_* to rf_*.
REQ-019 Grant: if no pipeline request and FIFO non-empty -> FIFO; if pipeline request and FIFO empty -> pipeline; if both -> pipeline unless starve_cnt == STARVE_LIMIT, then FIFO.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each cycle the pipeline is granted while count > 0, and SHALL clear on any FIFO grant or whenever count == 0.
REQ-021 wb_stall_o SHALL be 1 exactly when a pipeline request exists and FIFO is granted; combinational from current inputs and state.
REQ-022 On FIFO grant: rf_rd_addr_o/rf_rd_wdata_o = head entry; head pops at the clock edge.
REQ-023 On pipeline grant: rf_rd_addr_o/rf_rd_wdata_o = wb_rd_addr_i/wb_rd_wdata_i.
REQ-024 With no grant, rf_rd_addr_o = 0 and rf_rd_wdata_o = 0.
REQ-025 Simultaneous push and pop SHALL keep count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-026 The block SHALL NOT reorder or drop enqueued entries; WAW ordering between sources is enforced by the issue stage.
REQ-027 count width SHALL be $clog2(DEPTH)+1; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-028 While rst_i = 1: count = 0, pointers = 0, starve_cnt = 0, mdu_ready_o = 1, wb_stall_o = 0, FIFO contents don't-care.
REQ-029 With rst_i = 1 and any inputs, rf_rd_addr_o SHALL reflect only the pipeline path (FIFO empty); reset mid-operation SHALL discard all queued entries immediately.
REQ-030 Deassertion SHALL be honoured on the next rising edge with no spurious push or pop.

Verification
REQ-031 Idle pipeline (addr 0), push (rd=5, 0xDEAD_BEEF) -> next cycle rf_rd_addr_o=5, rf_rd_wdata_o=0xDEADBEEF, wb_stall_o=0, count back to 0.
REQ-032 Push 2 results back-to-back (DEPTH=2) -> mdu_ready_o=0 on cycle 3; third mdu_valid_i held until ready=1; all three retire in push order.
REQ-033 FIFO holds 1 entry, pipeline writes rd=7 every cycle -> 3 pipeline grants, 4th cycle FIFO granted with wb_stall_o=1, next cycle pipeline rd=7 granted with stall=0.
REQ-034 MDU push with rd=0 -> mdu_ready_o=1, count stays 0, no regfile write.
REQ-035 FIFO full, rst_i pulsed asynchronously mid-cycle -> count=0, mdu_ready_o=1, wb_stall_o=0 immediately; no queued entry written after release.
REQ-036 Simultaneous push and FIFO-grant pop at count=1 -> count stays 1, popped entry older, new entry retires next idle cycle.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the single register-file write port between the pipeline
//             write-back request and the head of a small in-order FIFO of
//             multi-cycle-unit (MDU) results. The pipeline has priority. The
//             FIFO is forced through once the pipeline has been granted
//             STARVE_LIMIT consecutive times while results are waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,   // MDU result FIFO entries, power of two, >= 2
    parameter int STARVE_LIMIT = 3    // pipeline grants tolerated while FIFO non-empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_rd_wdata_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_addr_i,
    input  logic [31:0] mdu_rd_wdata_i,
    output logic        mdu_ready_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_rd_wdata_o,
    output logic        wb_stall_o
);

    // Pointer width; a power-of-two DEPTH makes natural overflow the wrap.
    localparam int AW = $clog2(DEPTH);
    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    localparam int CW = $clog2(DEPTH) + 1;
    // Starvation counter must be able to hold STARVE_LIMIT itself.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    // FIFO storage (contents need no reset; occupancy gates every read)
    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          pipe_req;
    logic          fifo_req;
    logic          grant_fifo;
    logic          grant_pipe;
    logic          accept;
    logic          push;
    logic          pop;

    // Request decode and grant selection from current inputs and state.
    always_comb begin
        pipe_req   = (wb_rd_addr_i != 5'd0);
        fifo_req   = (count != '0);
        grant_fifo = fifo_req && (!pipe_req || (starve_cnt == LIMIT_C));
        grant_pipe = pipe_req && !grant_fifo;
        // Readiness comes only from registered occupancy: a full FIFO refuses
        // a result even if its head pops in the same cycle.
        mdu_ready_o = (count < DEPTH_C);
        accept      = mdu_valid_i && mdu_ready_o;
        // Results destined for x0 are acknowledged but never stored.
        push        = accept && (mdu_rd_addr_i != 5'd0);
        pop         = grant_fifo;
        wb_stall_o  = pipe_req && grant_fifo;
    end

    // Write-port mux: FIFO head, pipeline, or an idle (x0, zero) write.
    always_comb begin
        rf_rd_addr_o  = 5'd0;
        rf_rd_wdata_o = 32'd0;
        if (grant_fifo) begin
            rf_rd_addr_o  = addr_mem[rd_ptr];
            rf_rd_wdata_o = data_mem[rd_ptr];
        end else if (grant_pipe) begin
            rf_rd_addr_o  = wb_rd_addr_i;
            rf_rd_wdata_o = wb_rd_wdata_i;
        end
    end

    // FIFO storage write; no reset needed since count qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr] <= mdu_rd_addr_i;
            data_mem[wr_ptr] <= mdu_rd_wdata_i;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation tracking: counts pipeline wins while results wait, saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!fifo_req || grant_fifo) begin
            starve_cnt <= '0;
        end else if (grant_pipe && (starve_cnt != LIMIT_C)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Self-checking bench for wb_port_arbiter. A queue-based model
//             predicts every output each cycle; directed scenarios also pin
//             hand-computed literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_wdata_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_addr_i;
    logic [31:0] mdu_rd_wdata_i;
    logic        mdu_ready_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_wdata_o;
    logic        wb_stall_o;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .wb_rd_wdata_i  (wb_rd_wdata_i),
        .mdu_valid_i    (mdu_valid_i),
        .mdu_rd_addr_i  (mdu_rd_addr_i),
        .mdu_rd_wdata_i (mdu_rd_wdata_i),
        .mdu_ready_o    (mdu_ready_o),
        .rf_rd_addr_o   (rf_rd_addr_o),
        .rf_rd_wdata_o  (rf_rd_wdata_o),
        .wb_stall_o     (wb_stall_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending results in order, plus consecutive
    // pipeline wins while results are waiting.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];
    int   starve = 0;

    // Model predictions for the current cycle
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic        e_gfifo;
    logic        e_gpipe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit preq;
        bit freq;
        preq    = (wb_rd_addr_i != 5'd0);
        freq    = (mq.size() > 0);
        e_ready = (mq.size() < DEPTH);
        e_gfifo = freq && (!preq || starve >= LIMIT);
        e_gpipe = preq && !e_gfifo;
        e_stall = preq && e_gfifo;
        if (e_gfifo) begin
            e_addr = mq[0].a;
            e_data = mq[0].d;
        end else if (e_gpipe) begin
            e_addr = wb_rd_addr_i;
            e_data = wb_rd_wdata_i;
        end else begin
            e_addr = 5'd0;
            e_data = 32'd0;
        end
    endtask

    task automatic model_update();
        int sz;
        bit acc;
        sz  = mq.size();
        acc = mdu_valid_i && (sz < DEPTH);
        if (e_gfifo) void'(mq.pop_front());
        if (acc && mdu_rd_addr_i != 5'd0) mq.push_back('{a: mdu_rd_addr_i, d: mdu_rd_wdata_i});
        if (sz == 0 || e_gfifo) starve = 0;
        else if (e_gpipe) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    endtask

    task automatic drive(input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        wb_rd_addr_i   = wa;
        wb_rd_wdata_i  = wd;
        mdu_valid_i    = mv;
        mdu_rd_addr_i  = ma;
        mdu_rd_wdata_i = md;
    endtask

    // One clock: compare at the falling edge against the model (and
    // optionally against literal values), then advance the model.
    task automatic tick(input bit pin, input logic [4:0] pa, input logic [31:0] pd,
                        input logic ps, input logic pr);
        @(negedge clk);
        model_eval();
        check("rf_addr", {27'd0, rf_rd_addr_o}, {27'd0, e_addr});
        check("rf_data", rf_rd_wdata_o, e_data);
        check("wb_stall", {31'd0, wb_stall_o}, {31'd0, e_stall});
        check("mdu_ready", {31'd0, mdu_ready_o}, {31'd0, e_ready});
        if (pin) begin
            check("pin_addr", {27'd0, rf_rd_addr_o}, {27'd0, pa});
            check("pin_data", rf_rd_wdata_o, pd);
            check("pin_stall", {31'd0, wb_stall_o}, {31'd0, ps});
            check("pin_ready", {31'd0, mdu_ready_o}, {31'd0, pr});
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        bit hold_wb;
        bit hold_mdu;

        // Reset with arbitrary inputs: only the pipeline path is visible.
        rst_i = 1'b1;
        drive(5'd9, 32'h1234, 1'b1, 5'd3, 32'hABCD);
        #12;
        check("rst_ready", {31'd0, mdu_ready_o}, 32'd1);
        check("rst_stall", {31'd0, wb_stall_o}, 32'd0);
        check("rst_addr", {27'd0, rf_rd_addr_o}, 32'd9);
        check("rst_data", rf_rd_wdata_o, 32'h1234);
        @(negedge clk);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Single push with idle pipeline retires one cycle later.
        drive(5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Result for x0 is accepted and dropped.
        drive(5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Starvation: one queued entry, pipeline writing x7 every cycle.
        drive(5'd0, 32'd0, 1'b1, 5'd3, 32'hA5A5);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd7, 32'h77, 1'b0, 1'b1);
        tick(1, 5'd7, 32'h77, 1'b0, 1'b1);
        tick(1, 5'd7, 32'h77, 1'b0, 1'b1);
        tick(1, 5'd3, 32'hA5A5, 1'b1, 1'b1);
        tick(1, 5'd7, 32'h77, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Fill to full behind a busy pipeline; third result waits for ready.
        drive(5'd7, 32'h70, 1'b1, 5'd1, 32'h111);
        tick(1, 5'd7, 32'h70, 1'b0, 1'b1);
        drive(5'd7, 32'h70, 1'b1, 5'd2, 32'h222);
        tick(1, 5'd7, 32'h70, 1'b0, 1'b1);
        drive(5'd7, 32'h70, 1'b1, 5'd3, 32'h333);
        tick(1, 5'd7, 32'h70, 1'b0, 1'b0);
        drive(5'd0, 32'd0, 1'b1, 5'd3, 32'h333);
        tick(1, 5'd1, 32'h111, 1'b0, 1'b0);
        tick(1, 5'd2, 32'h222, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd3, 32'h333, 1'b0, 1'b1);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Push and pop together at one entry: order kept, newer retires next.
        drive(5'd0, 32'd0, 1'b1, 5'd4, 32'h444);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b1, 5'd6, 32'h666);
        tick(1, 5'd4, 32'h444, 1'b0, 1'b1);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(1, 5'd6, 32'h666, 1'b0, 1'b1);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Full FIFO, asynchronous reset mid-cycle discards everything.
        drive(5'd7, 32'h1, 1'b1, 5'd8, 32'h888);
        tick(0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive(5'd7, 32'h1, 1'b1, 5'd9, 32'h999);
        tick(0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive(5'd7, 32'h7, 1'b0, 5'd0, 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_ready", {31'd0, mdu_ready_o}, 32'd1);
        check("arst_stall", {31'd0, wb_stall_o}, 32'd0);
        check("arst_addr", {27'd0, rf_rd_addr_o}, 32'd7);
        mq.delete();
        starve = 0;
        @(negedge clk);
        drive(5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);
        tick(1, 5'd0, 32'd0, 1'b0, 1'b1);

        // Randomized traffic; sources hold their inputs while refused.
        for (int i = 0; i < 1500; i++) begin
            hold_wb  = e_stall;
            hold_mdu = mdu_valid_i && !e_ready;
            if (!hold_wb) begin
                wb_rd_addr_i  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_rd_wdata_i = $urandom;
            end
            if (!hold_mdu) begin
                mdu_valid_i    = ($urandom_range(0, 9) < 4);
                mdu_rd_addr_i  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdu_rd_wdata_i = $urandom;
            end
            tick(0, 5'd0, 32'd0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
